// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch and EX/MEM data
// accesses, with a one-entry fetch buffer and a bus-timeout watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic        if_flush,
    input  logic [63:0] if_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic        m_req,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        m_ready,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic [63:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_if,
    output logic        stall_pipe,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_BUSY,
        M_DONE,
        IF_BUSY
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       ibuf_full;
    logic       discard;
    logic       mem_pending;
    logic       busy;
    logic       timeout;
    logic       xfer_done;
    logic       fetch_go;

    assign mem_pending = mem_read | mem_write;
    assign busy        = (state == MEM_BUSY) | (state == IF_BUSY);
    assign timeout     = busy & ~m_ready & (wait_cnt == TO_LAST);
    assign xfer_done   = busy & (m_ready | timeout);
    assign fetch_go    = ~mem_pending & if_req & ~ibuf_full;

    assign m_req      = busy;
    assign mem_done   = (state == M_DONE);
    assign stall_pipe = mem_pending & (state != M_DONE);
    assign if_valid   = ibuf_full & ~stall_pipe & ~if_flush;
    assign stall_if   = if_req & ~if_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (mem_pending)   state_nxt = MEM_BUSY;
                else if (fetch_go) state_nxt = IF_BUSY;
            end
            MEM_BUSY: if (xfer_done) state_nxt = M_DONE;
            M_DONE:   state_nxt = IDLE;
            IF_BUSY:  if (xfer_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            mem_rdata <= '0;
            if_rdata  <= '0;
            ibuf_full <= 1'b0;
            discard   <= 1'b0;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (!busy)
                wait_cnt <= '0;
            else if (!m_ready)
                wait_cnt <= wait_cnt + 8'd1;

            if (timeout) bus_err <= 1'b1;

            if (state == IDLE) begin
                if (mem_pending) begin
                    m_addr  <= mem_addr;
                    m_we    <= mem_write;
                    m_wdata <= mem_wdata;
                end else if (fetch_go) begin
                    m_addr <= if_addr;
                    m_we   <= 1'b0;
                end
            end

            // a timed-out load returns zero
            if (state == MEM_BUSY && xfer_done && !m_we)
                mem_rdata <= timeout ? 64'd0 : m_rdata;

            if (if_flush | if_valid) ibuf_full <= 1'b0;

            // flushed fetches finish on the bus, but their data is dropped
            if (state == IF_BUSY) begin
                if (xfer_done) begin
                    discard <= 1'b0;
                    if (!discard && !if_flush) begin
                        if_rdata  <= timeout ? 32'h0000_0013 : m_rdata[31:0];
                        ibuf_full <= 1'b1;
                    end
                end else if (if_flush) begin
                    discard <= 1'b1;
                end
            end
        end
    end

endmodule
